// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the fetch PC, applies load-use stalls and EX-resolved redirects,
// and keeps saturating stall/flush event counters for trace/debug.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned IROM_AW  = 14,
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst_n,
    input  logic               pipeline_stop_PC,
    input  logic               pipeline_stop_REG_IF_ID,
    input  logic               flush_REG_ID_EX_hz,
    input  logic               jump_EX,
    input  logic [31:0]        jump_target_EX,
    input  logic [31:0]        irom_inst,
    output logic [IROM_AW-1:0] irom_adr,
    output logic [31:0]        pc_IF,
    output logic [31:0]        inst_ID,
    output logic [31:0]        pc_ID,
    output logic [31:0]        pc4_ID,
    output logic               valid_ID,
    output logic               flush_ID_EX,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam int unsigned XLEN = 32;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic            valid;
    } ifid_t;

    logic [XLEN-1:0]  pc_q,    pc_d;
    ifid_t            ifid_q,  ifid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  redirect_pc;
    ifid_t            ifid_bubble;
    ifid_t            ifid_fetch;
    logic             stall_event;
    logic             flush_event;

    // Only word-aligned targets are fetched; the low target bits are dropped.
    logic unused_target_lsbs;
    assign unused_target_lsbs = &{1'b0, jump_target_EX[1:0]};

    // Sequential PC and wrap-around increment
    assign pc_plus4    = pc_q + XLEN'(4);
    assign redirect_pc = {jump_target_EX[XLEN-1:2], 2'b00};

    // Bubble and freshly fetched IF/ID payloads
    always_comb begin
        ifid_bubble       = '0;
        ifid_bubble.inst  = NOP_INST;
        ifid_bubble.pc    = '0;
        ifid_bubble.pc4   = '0;
        ifid_bubble.valid = 1'b0;

        ifid_fetch        = '0;
        ifid_fetch.inst   = irom_inst;
        ifid_fetch.pc     = pc_q;
        ifid_fetch.pc4    = pc_plus4;
        ifid_fetch.valid  = 1'b1;
    end

    // Next PC / IF-ID selection: redirect beats stall beats advance
    always_comb begin
        pc_d   = pc_q;
        ifid_d = ifid_q;
        if (jump_EX) begin
            pc_d   = redirect_pc;
            ifid_d = ifid_bubble;
        end else if (pipeline_stop_PC) begin
            // PC frozen; IF/ID either holds or takes a bubble so ID does not
            // see the same instruction twice.
            if (!pipeline_stop_REG_IF_ID) begin
                ifid_d = ifid_bubble;
            end
        end else begin
            pc_d = pc_plus4;
            // Holding IF/ID while the PC advances is an illegal request; the
            // hold is still honoured and flagged by the assertion below.
            if (!pipeline_stop_REG_IF_ID) begin
                ifid_d = ifid_fetch;
            end
        end
    end

    // Saturating event counters
    assign stall_event = pipeline_stop_PC & ~jump_EX;
    assign flush_event = jump_EX;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_event && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_event && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rst_n) begin
            pc_q        <= RESET_PC;
            ifid_q      <= ifid_bubble;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            ifid_q      <= ifid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Output mapping; irom_adr and flush_ID_EX are combinational by design
    assign irom_adr    = pc_q[IROM_AW+1:2];
    assign pc_IF       = pc_q;
    assign inst_ID     = ifid_q.inst;
    assign pc_ID       = ifid_q.pc;
    assign pc4_ID      = ifid_q.pc4;
    assign valid_ID    = ifid_q.valid;
    assign flush_ID_EX = flush_REG_ID_EX_hz | jump_EX;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

    // Hazard unit must never hold IF/ID while letting the PC run
    a_no_ifid_hold_without_pc_hold : assert property (
        @(posedge cpu_clk) disable iff (!cpu_rst_n)
        !(pipeline_stop_REG_IF_ID && !pipeline_stop_PC && !jump_EX)
    ) else $error("if_stage: IF/ID hold requested while PC advances");

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, fetch, stalls, redirects, reset
// mid-stall, counter saturation (narrow-counter instance) and PC wrap.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n;
    logic        pipeline_stop_PC;
    logic        pipeline_stop_REG_IF_ID;
    logic        flush_REG_ID_EX_hz;
    logic        jump_EX;
    logic [31:0] jump_target_EX;
    logic [31:0] irom_inst;
    logic [13:0] irom_adr;
    logic [31:0] pc_IF, inst_ID, pc_ID, pc4_ID;
    logic        valid_ID, flush_ID_EX;
    logic [15:0] stall_cnt, flush_cnt;

    // Narrow-counter instance for saturation
    logic [31:0] irom_inst4;
    logic [13:0] irom_adr4;
    logic [31:0] pc_IF4, inst_ID4, pc_ID4, pc4_ID4;
    logic        valid_ID4, flush_ID_EX4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int n_pass  = 0;
    int n_total = 0;

    always #5 cpu_clk = ~cpu_clk;

    // Instruction ROM model: word 0 holds addi x1,x0,1; others encode address
    assign irom_inst  = (irom_adr == 14'd0) ? 32'h0010_0093 : (32'hC000_0000 | 32'(irom_adr));
    assign irom_inst4 = (irom_adr4 == 14'd0) ? 32'h0010_0093 : (32'hC000_0000 | 32'(irom_adr4));

    if_stage u_dut (
        .cpu_clk                 (cpu_clk),
        .cpu_rst_n               (cpu_rst_n),
        .pipeline_stop_PC        (pipeline_stop_PC),
        .pipeline_stop_REG_IF_ID (pipeline_stop_REG_IF_ID),
        .flush_REG_ID_EX_hz      (flush_REG_ID_EX_hz),
        .jump_EX                 (jump_EX),
        .jump_target_EX          (jump_target_EX),
        .irom_inst               (irom_inst),
        .irom_adr                (irom_adr),
        .pc_IF                   (pc_IF),
        .inst_ID                 (inst_ID),
        .pc_ID                   (pc_ID),
        .pc4_ID                  (pc4_ID),
        .valid_ID                (valid_ID),
        .flush_ID_EX             (flush_ID_EX),
        .stall_cnt               (stall_cnt),
        .flush_cnt               (flush_cnt)
    );

    if_stage #(.CNT_W(4)) u_dut4 (
        .cpu_clk                 (cpu_clk),
        .cpu_rst_n               (cpu_rst_n),
        .pipeline_stop_PC        (pipeline_stop_PC),
        .pipeline_stop_REG_IF_ID (pipeline_stop_REG_IF_ID),
        .flush_REG_ID_EX_hz      (flush_REG_ID_EX_hz),
        .jump_EX                 (jump_EX),
        .jump_target_EX          (jump_target_EX),
        .irom_inst               (irom_inst4),
        .irom_adr                (irom_adr4),
        .pc_IF                   (pc_IF4),
        .inst_ID                 (inst_ID4),
        .pc_ID                   (pc_ID4),
        .pc4_ID                  (pc4_ID4),
        .valid_ID                (valid_ID4),
        .flush_ID_EX             (flush_ID_EX4),
        .stall_cnt               (stall_cnt4),
        .flush_cnt               (flush_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    initial begin
        cpu_rst_n               = 1'b0;
        pipeline_stop_PC        = 1'b0;
        pipeline_stop_REG_IF_ID = 1'b0;
        flush_REG_ID_EX_hz      = 1'b0;
        jump_EX                 = 1'b0;
        jump_target_EX          = 32'h0;

        // Reset state
        tick();
        tick();
        chk("rst_pc",      pc_IF, 32'h0);
        chk("rst_inst",    inst_ID, NOP);
        chk("rst_pc_id",   pc_ID, 32'h0);
        chk("rst_pc4_id",  pc4_ID, 32'h0);
        chk("rst_valid",   32'(valid_ID), 32'h0);
        chk("rst_stall",   32'(stall_cnt), 32'h0);
        chk("rst_flush",   32'(flush_cnt), 32'h0);
        chk("rst_fl_idex", 32'(flush_ID_EX), 32'h0);

        // Release and free-run fetch
        cpu_rst_n = 1'b1;
        tick();
        chk("e1_pc",     pc_IF, 32'h4);
        chk("e1_inst",   inst_ID, 32'h0010_0093);
        chk("e1_pc_id",  pc_ID, 32'h0);
        chk("e1_pc4_id", pc4_ID, 32'h4);
        chk("e1_valid",  32'(valid_ID), 32'h1);
        tick();
        chk("e2_pc",     pc_IF, 32'h8);
        chk("e2_inst",   inst_ID, 32'hC000_0001);
        chk("e2_pc_id",  pc_ID, 32'h4);

        // Load-use stall, both stops, one cycle at pc 8
        pipeline_stop_PC        = 1'b1;
        pipeline_stop_REG_IF_ID = 1'b1;
        #1;
        chk("st_fl_idex", 32'(flush_ID_EX), 32'h0);
        tick();
        chk("st_pc",     pc_IF, 32'h8);
        chk("st_pc_id",  pc_ID, 32'h4);
        chk("st_inst",   inst_ID, 32'hC000_0001);
        chk("st_valid",  32'(valid_ID), 32'h1);
        chk("st_cnt",    32'(stall_cnt), 32'h1);
        pipeline_stop_PC        = 1'b0;
        pipeline_stop_REG_IF_ID = 1'b0;
        tick();
        chk("ps_pc",     pc_IF, 32'hC);
        chk("ps_pc_id",  pc_ID, 32'h8);
        chk("ps_inst",   inst_ID, 32'hC000_0002);

        // PC-only stall inserts a bubble into IF/ID
        pipeline_stop_PC = 1'b1;
        tick();
        chk("pb_pc",     pc_IF, 32'hC);
        chk("pb_inst",   inst_ID, NOP);
        chk("pb_valid",  32'(valid_ID), 32'h0);
        chk("pb_pc_id",  pc_ID, 32'h0);
        chk("pb_cnt",    32'(stall_cnt), 32'h2);
        pipeline_stop_PC = 1'b0;
        tick();
        chk("pa_pc",     pc_IF, 32'h10);
        chk("pa_pc_id",  pc_ID, 32'hC);
        chk("pa_inst",   inst_ID, 32'hC000_0003);

        // Redirect at pc 16 to misaligned target
        jump_EX        = 1'b1;
        jump_target_EX = 32'h0000_0103;
        #1;
        chk("rd_fl_idex", 32'(flush_ID_EX), 32'h1);
        tick();
        chk("rd_pc",     pc_IF, 32'h100);
        chk("rd_inst",   inst_ID, NOP);
        chk("rd_valid",  32'(valid_ID), 32'h0);
        chk("rd_fcnt",   32'(flush_cnt), 32'h1);
        chk("rd_scnt",   32'(stall_cnt), 32'h2);
        jump_EX = 1'b0;

        // Hazard-unit bubble request passes straight through
        flush_REG_ID_EX_hz = 1'b1;
        #1;
        chk("hz_fl_idex", 32'(flush_ID_EX), 32'h1);
        flush_REG_ID_EX_hz = 1'b0;
        #1;
        chk("hz_fl_off",  32'(flush_ID_EX), 32'h0);

        // Redirect together with both stops: redirect wins
        jump_EX                 = 1'b1;
        jump_target_EX          = 32'h0000_0200;
        pipeline_stop_PC        = 1'b1;
        pipeline_stop_REG_IF_ID = 1'b1;
        tick();
        chk("rs_pc",     pc_IF, 32'h200);
        chk("rs_valid",  32'(valid_ID), 32'h0);
        chk("rs_inst",   inst_ID, NOP);
        chk("rs_scnt",   32'(stall_cnt), 32'h2);
        chk("rs_fcnt",   32'(flush_cnt), 32'h2);
        jump_EX                 = 1'b0;
        pipeline_stop_PC        = 1'b0;
        pipeline_stop_REG_IF_ID = 1'b0;
        tick();
        chk("ra_pc",     pc_IF, 32'h204);
        chk("ra_inst",   inst_ID, 32'hC000_0080);
        chk("ra_pc_id",  pc_ID, 32'h200);
        chk("ra_pc4_id", pc4_ID, 32'h204);

        // Reset during a stall at pc 0x40 with a pending redirect
        jump_EX        = 1'b1;
        jump_target_EX = 32'h0000_0040;
        tick();
        chk("r40_pc",    pc_IF, 32'h40);
        jump_EX                 = 1'b0;
        pipeline_stop_PC        = 1'b1;
        pipeline_stop_REG_IF_ID = 1'b1;
        tick();
        chk("r40_hold",  pc_IF, 32'h40);
        chk("r40_scnt",  32'(stall_cnt), 32'h3);
        jump_EX        = 1'b1;
        jump_target_EX = 32'h0000_0500;
        cpu_rst_n      = 1'b0;
        tick();
        chk("mr_pc",     pc_IF, 32'h0);
        chk("mr_valid",  32'(valid_ID), 32'h0);
        chk("mr_inst",   inst_ID, NOP);
        chk("mr_scnt",   32'(stall_cnt), 32'h0);
        chk("mr_fcnt",   32'(flush_cnt), 32'h0);
        cpu_rst_n               = 1'b1;
        jump_EX                 = 1'b0;
        pipeline_stop_PC        = 1'b0;
        pipeline_stop_REG_IF_ID = 1'b0;
        tick();
        chk("mr1_pc",    pc_IF, 32'h4);
        chk("mr1_inst",  inst_ID, 32'h0010_0093);
        chk("mr1_valid", 32'(valid_ID), 32'h1);

        // Saturation: 20 stall cycles
        pipeline_stop_PC        = 1'b1;
        pipeline_stop_REG_IF_ID = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        chk("sat4_14",   32'(stall_cnt4), 32'hE);
        for (int i = 0; i < 6; i++) tick();
        chk("sat4_20",   32'(stall_cnt4), 32'hF);
        chk("sat16_20",  32'(stall_cnt), 32'd20);
        chk("sat_pc",    pc_IF, 32'h4);
        pipeline_stop_PC        = 1'b0;
        pipeline_stop_REG_IF_ID = 1'b0;

        // PC wrap from the top of the address space
        jump_EX        = 1'b1;
        jump_target_EX = 32'hFFFF_FFFF;
        tick();
        chk("wr_pc",     pc_IF, 32'hFFFF_FFFC);
        chk("wr_adr",    32'(irom_adr), 32'h3FFF);
        jump_EX = 1'b0;
        tick();
        chk("wr_pc0",    pc_IF, 32'h0);
        chk("wr_pc_id",  pc_ID, 32'hFFFF_FFFC);
        chk("wr_pc4_id", pc4_ID, 32'h0);
        chk("wr_inst",   inst_ID, 32'hC000_3FFF);
        chk("wr_valid",  32'(valid_ID), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the ID stage and the data-hazard detection unit.
- Owns the PC and drives the instruction-ROM address.
- Captures the fetched instruction into IF/ID.
- Obeys the load-use stall controls the hazard unit produces.
- Applies control-hazard redirects resolved in EX, squashing wrong-path instructions.
- Keeps saturating stall and flush event counters for trace/debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
IROM_AW, 14, instruction-ROM word-address width
NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID on reset/flush
CNT_W, 16, width of the stall and flush event counters

Ports:
cpu_clk  in  1  clock; all state updates on rising edge
cpu_rst_n  in  1  synchronous, active-low reset
pipeline_stop_PC  in  1  hold PC (load-use stall from hazard unit)
pipeline_stop_REG_IF_ID  in  1  hold IF/ID register (load-use stall)
flush_REG_ID_EX_hz  in  1  hazard-unit bubble request for ID/EX
jump_EX  in  1  taken branch/jump resolved in EX this cycle
jump_target_EX  in  32  redirect target from EX
irom_inst  in  32  instruction word; combinational read at irom_adr
irom_adr  out  IROM_AW  = pc_IF[IROM_AW+1:2]
pc_IF  out  32  current fetch PC
inst_ID  out  32  IF/ID instruction
pc_ID  out  32  IF/ID PC
pc4_ID  out  32  IF/ID PC+4, registered
valid_ID  out  1  IF/ID holds a real (non-bubble) instruction; used by the trace path
flush_ID_EX  out  1  combined ID/EX flush = flush_REG_ID_EX_hz | jump_EX
stall_cnt  out  CNT_W  cycles with pipeline_stop_PC=1 and jump_EX=0, saturating
flush_cnt  out  CNT_W  cycles with jump_EX=1, saturating

Behaviour:
- Reset (cpu_rst_n=0 at a rising edge), regardless of other inputs:
  - pc_IF=RESET_PC
  - inst_ID=NOP_INST, pc_ID=0, pc4_ID=0, valid_ID=0
  - stall_cnt=0, flush_cnt=0
- Reset asserted mid-operation discards any pending stall or redirect; the first fetch after release is RESET_PC.
- Fetch latency is 1 cycle. irom_inst for pc_IF is captured into IF/ID at the next edge, so the first real instruction appears in IF/ID one edge after reset release.
- Per-edge priority when not in reset: redirect > stall > advance.
  - Redirect (jump_EX=1):
    - pc_IF <= {jump_target_EX[31:2],2'b00}; low bits are cleared, no misalignment trap.
    - IF/ID <= NOP_INST / pc 0 / valid 0.
    - flush_ID_EX=1 the same cycle, which kills the wrong-path instruction currently in ID.
    - Redirect overrides any simultaneous pipeline_stop_PC / pipeline_stop_REG_IF_ID.
  - Stall (jump_EX=0, pipeline_stop_PC=1): pc_IF holds.
    - If pipeline_stop_REG_IF_ID=1, all IF/ID fields hold.
    - If only pipeline_stop_PC=1, IF/ID is loaded with a bubble (valid 0); this keeps the PC/IF-ID split legal.
  - Advance: pc_IF <= pc_IF+4 (32-bit wrap; 32'hFFFF_FFFC -> 0). IF/ID <= irom_inst, pc_IF, pc_IF+4, valid 1.
  - pipeline_stop_REG_IF_ID=1 with pipeline_stop_PC=0 is illegal. Behaviour: PC advances and IF/ID holds. This is flagged by an assertion in simulation.
- flush_ID_EX is purely combinational, with no register.
- Counters increment by 1 per qualifying cycle, saturate at all-ones (no wrap), and hold during reset-free idle.
- irom_adr is a combinational slice of pc_IF; bits above IROM_AW+1 are ignored (address aliasing is accepted).

Test Plan:
- Reset release, no stalls, irom returns 32'h0010_0093 at word 0:
  - pc_IF sequence 0,4,8 on successive edges.
  - inst_ID=32'h0010_0093, pc_ID=0, pc4_ID=4, valid_ID=1 after edge 1.
- Load-use stall: both stop signals high for 1 cycle while pc_IF=8:
  - pc_IF stays 8 and IF/ID holds pc_ID=4 for one extra cycle.
  - stall_cnt=1.
  - pc_IF=12 on the edge after the stall drops.
- Redirect: jump_EX=1, jump_target_EX=32'h0000_0103 at pc_IF=16:
  - flush_ID_EX=1 that cycle.
  - Next edge pc_IF=32'h0000_0100, inst_ID=NOP_INST, valid_ID=0, flush_cnt=1.
- Simultaneous jump_EX=1 and both stops=1:
  - Redirect wins: pc_IF=target, IF/ID bubble, stall_cnt unchanged.
- cpu_rst_n=0 for one edge during a stall at pc_IF=32'h40:
  - pc_IF=RESET_PC, valid_ID=0, both counters 0.
- Force stall_cnt to saturate with CNT_W=4 and 20 stall cycles:
  - stall_cnt stops at 15.
- Wrap check: force pc_IF=32'hFFFF_FFFC and advance:
  - pc_IF=0, pc4_ID=0.
